uart_tx_sender: RTL and testbench
=================================

UART_TX_SENDER -- requirements
Module: uart_tx_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning the FIFO holds 2**FIFO_DEPTH_LOG2 bytes (default 16).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port push_send_data  input  1  one-cycle request to enqueue send_data.
REQ-006 SHALL have port send_data  input  8  byte to enqueue; sampled only when push_send_data=1.
REQ-007 SHALL have port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-008 SHALL have port tx_full  output  1  FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
REQ-009 SHALL have port tx_busy  output  1  FIFO non-empty or frame in progress.
REQ-010 SHALL have port overflow  output  1  sticky flag: a push was dropped.
REQ-011 SHALL have port fifo_count  output  FIFO_DEPTH_LOG2+1  bytes currently queued, excluding the byte being shifted.

Function
REQ-012 SHALL implement the FIFO as a circular buffer with wrap-around read/write pointers and a count of FIFO_DEPTH_LOG2+1 bits.
REQ-013 SHALL accept a push only when tx_full=0 at the start of the cycle; a simultaneous pop does not make room for a push when full.
REQ-014 SHALL drop a push made while full, leave FIFO contents unchanged, and set overflow to 1 until reset.
REQ-015 SHALL, on simultaneous accepted push and pop, write and read in the same cycle with count unchanged.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1. When the FIFO is non-empty, SHALL pop the head byte into the shift register, clear the bit timer, and go to START.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-019 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after bit index 7, go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-021 Latency: a push at cycle N into an empty FIFO with the FSM in IDLE SHALL drive the start bit from cycle N+2.
REQ-022 Back-to-back frames SHALL be separated by exactly one IDLE cycle, giving a period of 10*CLKS_PER_BIT+1 cycles.
REQ-023 tx, tx_full, tx_busy and fifo_count SHALL be registered outputs with no combinational path from the inputs.
REQ-024 The bit timer SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at every bit boundary.

Reset
REQ-025 When reset=0 at a clock edge, SHALL set: state IDLE, tx=1, pointers 0, fifo_count 0, tx_full 0, tx_busy 0, overflow 0, bit timer 0, bit index 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, return tx to 1 on the next edge, and discard all queued bytes.
REQ-027 A push in the same cycle as reset=0 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2 bits), the default CLKS_PER_BIT and the default FIFO_DEPTH_LOG2.
REQ-029 The FIFO SHALL be a separate sub-module, send_fifo, with push, pop, din, dout, full, empty and count ports; the FSM and shifter stay in uart_tx_sender.
REQ-030 The block's tx_full SHALL be usable by the CPU's waiting_signal_watcher as the stall condition for send instructions.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=4)
REQ-031 Single byte: push 0x55 at cycle 10 -> tx low cycles 12-15, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, high cycles 48-51; tx_busy drops at cycle 52.
REQ-032 Burst: push 0x01, 0x80, 0xFF on consecutive cycles -> three frames decoded in order, start bits 41 cycles apart; fifo_count peaks at 2.
REQ-033 Overflow: 17 pushes on consecutive cycles while frame 1 is shifting -> 16 bytes plus the first frame transmitted, 1 dropped, overflow=1 from the drop cycle until reset.
REQ-034 Full with simultaneous pop: FIFO full, push 0xA5 on the same cycle IDLE pops -> 0xA5 dropped, overflow=1, count goes 16->15.
REQ-035 Reset mid-frame: reset=0 during DATA bit 3 of 0xC3 with 2 bytes queued -> tx=1 the next cycle, fifo_count=0, no further frames.
REQ-036 Wrap-around: 40 bytes 0x00..0x27 pushed at a rate matching the drain -> all 40 received in order; pointers wrap twice without loss.

Source files
------------

// File: rtl/uart_tx_sender_pkg.sv
// uart_tx_sender_pkg
// Shared definitions for the UART transmit path: the 2-bit FSM state
// encoding and the default parameter values used by uart_tx_sender and
// send_fifo.
package uart_tx_sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT    = 868;
  localparam int DEFAULT_FIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/send_fifo.sv
// send_fifo
// Circular byte FIFO that sits in front of the UART serializer.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-low reset
//   push, din   - enqueue request and byte; ignored while full
//   pop         - dequeue request; ignored while empty
//   dout        - head byte (valid while empty=0)
//   full, empty - registered status flags
//   count       - registered occupancy, 0..2**DEPTH_LOG2
module send_fifo
  import uart_tx_sender_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  // Full is judged on the registered flag, so a pop in the same cycle
  // never frees a slot for a push that arrives while full.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + (DEPTH_LOG2+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt;
      full  <= (count_nxt == (DEPTH_LOG2+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_sender.sv
// uart_tx_sender
// Queued 8N1 UART transmitter: bytes are pushed into send_fifo and the
// serializer FSM drains them LSB first, one IDLE cycle between frames.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-low reset
//   push_send_data        - one-cycle enqueue strobe for send_data
//   send_data             - byte to enqueue
//   tx                    - serial line, idle high (registered)
//   tx_full               - FIFO full; usable as a send-stall condition
//   tx_busy               - FIFO non-empty or frame in progress (registered)
//   overflow              - sticky: a push was dropped since reset
//   fifo_count            - bytes queued, excluding the one being shifted
//
// state | meaning
// IDLE  | line high; pops head byte when FIFO non-empty
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | data bits shift[0], LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_sender
  import uart_tx_sender_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_send_data,
  input  logic [7:0]               send_data,
  output logic                     tx,
  output logic                     tx_full,
  output logic                     tx_busy,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  tx_state_t   state, state_nxt;
  logic [15:0] bit_timer, bit_timer_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        tx_nxt;
  logic        busy_nxt;
  logic        pop;
  logic        push_ok;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        bit_done;

  send_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_send_data),
    .pop   (pop),
    .din   (send_data),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_done = (bit_timer == 16'(CLKS_PER_BIT - 1));
  assign push_ok  = push_send_data & ~tx_full;

  always_comb begin
    state_nxt     = state;
    bit_timer_nxt = bit_done ? 16'd0 : bit_timer + 16'd1;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        bit_timer_nxt = 16'd0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered from the next state so the line changes on the same
    // edge as the FSM, giving the start bit two cycles after the push.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase

    // Predict FIFO occupancy after this edge so tx_busy can be a flop.
    busy_nxt = (state_nxt != IDLE) || push_ok ||
               (fifo_count > (FIFO_DEPTH_LOG2+1)'(1)) ||
               ((fifo_count == (FIFO_DEPTH_LOG2+1)'(1)) && !pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_timer <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_timer <= bit_timer_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      tx        <= tx_nxt;
      tx_busy   <= busy_nxt;
      if (push_send_data && tx_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sender.sv
// tb_uart_tx_sender
// Scoreboard bench: accepted bytes are queued by a queue-level reference
// model; a UART line decoder pops and compares each received frame, and
// the status outputs are compared against the model every cycle.
module tb_uart_tx_sender;

  localparam int CPB   = 4;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       push_send_data = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       tx;
  logic       tx_full;
  logic       tx_busy;
  logic       overflow;
  logic [4:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_sender #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG2(DL2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push_send_data(push_send_data),
    .send_data     (send_data),
    .tx            (tx),
    .tx_full       (tx_full),
    .tx_busy       (tx_busy),
    .overflow      (overflow),
    .fifo_count    (fifo_count)
  );

  // Reference model: a byte queue plus the number of line cycles left in
  // the frame being sent. A frame may start only in a cycle where no
  // frame is active, which is the single idle cycle between frames.
  byte unsigned m_q[$];
  int           m_frame_left = 0;
  logic [7:0]   m_cur = 8'h00;
  bit           m_ovf = 1'b0;
  bit           started = 1'b0;
  logic [7:0]   exp_mem [0:4095];
  int           exp_wr = 0;
  int           flush_mark = 0;
  int           rst_count = 0;

  always @(posedge clk) begin : model
    bit full0;
    if (!reset) begin
      m_q.delete();
      m_frame_left = 0;
      m_ovf        = 1'b0;
      started      = 1'b1;
      flush_mark   = exp_wr;
      rst_count    = rst_count + 1;
    end else begin
      full0 = (m_q.size() == DEPTH);
      if (m_frame_left == 0 && m_q.size() > 0) begin
        m_cur        = m_q.pop_front();
        m_frame_left = FRAME;
      end else if (m_frame_left > 0) begin
        m_frame_left = m_frame_left - 1;
      end
      if (push_send_data) begin
        if (full0) begin
          m_ovf = 1'b1;
        end else begin
          m_q.push_back(send_data);
          exp_mem[exp_wr % 4096] = send_data;
          exp_wr = exp_wr + 1;
        end
      end
    end
  end

  // Monitor: per-cycle status checks, frame decoding and the summary.
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_rd = 0;
  int         seen_rst = 0;
  bit         dec_active = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  int         cycles = 0;
  bit         done = 1'b0;
  int         to_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic e_tx;
    int   p;
    cycles = cycles + 1;
    if (started) begin
      e_tx = 1'b1;
      if (m_frame_left > 0) begin
        p = FRAME - m_frame_left;
        if (p / CPB == 0)      e_tx = 1'b0;
        else if (p / CPB == 9) e_tx = 1'b1;
        else                   e_tx = m_cur[p / CPB - 1];
      end
      chk("tx", {31'd0, tx}, {31'd0, e_tx});
      chk("fifo_count", {27'd0, fifo_count}, m_q.size());
      chk("tx_full", {31'd0, tx_full}, {31'd0, m_q.size() == DEPTH});
      chk("tx_busy", {31'd0, tx_busy}, {31'd0, (m_q.size() > 0) || (m_frame_left > 0)});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});

      if (seen_rst != rst_count) begin
        seen_rst   = rst_count;
        dec_active = 1'b0;
        exp_rd     = flush_mark;
      end else if (!dec_active) begin
        if (tx == 1'b0) begin
          dec_active = 1'b1;
          dec_cnt    = 0;
        end
      end else begin
        dec_cnt = dec_cnt + 1;
        if (dec_cnt == CPB / 2) begin
          chk("start_bit", {31'd0, tx}, 32'd0);
        end else if (dec_cnt >= CPB + CPB / 2 && dec_cnt < 9 * CPB &&
                     (dec_cnt - CPB / 2) % CPB == 0) begin
          dec_byte[(dec_cnt - CPB / 2) / CPB - 1] = tx;
        end else if (dec_cnt == 9 * CPB + CPB / 2) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          dec_active = 1'b0;
          if (exp_rd >= exp_wr) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL unexpected_frame: got byte %0h expected no frame at %0t", dec_byte, $time);
          end else begin
            chk("frame_byte", {24'd0, dec_byte}, {24'd0, exp_mem[exp_rd % 4096]});
            exp_rd = exp_rd + 1;
          end
        end
      end
    end

    if (done || cycles > 60000) begin
      chk("watchdog", {31'd0, cycles > 60000}, 32'd0);
      chk("wait_timeouts", to_count, 32'd0);
      chk("frames_outstanding", exp_rd, exp_wr);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  // Stimulus: every task starts and ends just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push1(input logic [7:0] b);
    push_send_data = 1'b1;
    send_data      = b;
    @(negedge clk);
    push_send_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) to_count = to_count + 1;
    cyc(3);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b0;
    cyc(n);
    reset = 1'b1;
    cyc(3);
  endtask

  initial begin : stim
    int n;
    cyc(3);
    reset = 1'b1;
    cyc(5);

    // single byte
    push1(8'h55);
    wait_idle(200);

    // three-byte burst
    push1(8'h01);
    push1(8'h80);
    push1(8'hFF);
    wait_idle(400);

    // 17 pushes while the first frame shifts: one is dropped
    push1(8'($urandom));
    cyc(3);
    for (int i = 0; i < 17; i++) push1(8'($urandom));
    wait_idle(2000);
    pulse_reset(2);

    // full FIFO, push coinciding with the idle-cycle pop
    for (int i = 0; i < 17; i++) push1(8'($urandom));
    n = 0;
    while (!(m_frame_left == 0 && m_q.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) to_count = to_count + 1;
    push1(8'hA5);
    wait_idle(2000);
    pulse_reset(2);

    // reset during data bit 3 of 0xC3 with two bytes queued
    push1(8'hC3);
    push1(8'h11);
    push1(8'h22);
    n = 0;
    while (m_frame_left != FRAME - (CPB * 4 + 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) to_count = to_count + 1;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(200);

    // 40 bytes at the drain rate: pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      push1(8'(i));
      cyc(FRAME);
    end
    wait_idle(400);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) push1(8'($urandom));
      else cyc(1);
    end
    wait_idle(4000);

    done = 1'b1;
  end

endmodule
